step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have one parameter: NrOfSteps, default 10, number of timing steps per instruction cycle (legal range 2..16).
REQ-002 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Tick  input  1  clock enable; all state advances are qualified by Tick=1.
REQ-005 Run  input  1  start request; sampled only in IDLE.
REQ-006 Halt  input  1  stop request; honoured at the next cycle boundary.
REQ-007 Last_Step  input  4  index of the final step of the current instruction (early end); values >= NrOfSteps are treated as NrOfSteps-1.
REQ-008 Step  output  NrOfSteps  one-hot timing lines T1..Tn for the control-unit AND-gate decoders; all zero when not running.
REQ-009 Step_Index  output  4  binary index of the active step (0 when idle).
REQ-010 Busy  output  1  high in RUN.
REQ-011 Cycle_Done  output  1  one-Clock pulse when the last step completes.

Function
REQ-012 States: IDLE, RUN; encoding fixed in the package.
REQ-013 IDLE -> RUN on Tick=1 & Run=1 & Halt=0; on the same edge Step=1 (bit 0) and Step_Index=0.
REQ-014 In IDLE with Run=1 & Halt=1 on a Tick, the block SHALL stay in IDLE (Halt wins).
REQ-015 In RUN, each Tick=1 advances Step_Index by 1 and shifts Step left by one; Tick=0 holds all outputs.
REQ-016 In RUN with Tick=1 and Step_Index == effective Last_Step: Cycle_Done=1 for exactly that Clock; if Halt=0, wrap to index 0 (Step bit 0); if Halt=1, go to IDLE with Step=0, Busy=0.
REQ-017 Last_Step SHALL be sampled on every Tick; a change mid-cycle to a value below the current index ends the cycle on the next Tick (treated as reached).
REQ-018 Run is ignored while in RUN; Halt is never lost: a Halt pulse during RUN SHALL be latched until the cycle boundary.
REQ-019 Step SHALL always be either all-zero (IDLE) or exactly one-hot (RUN); latency from Tick to output change is one Clock.

Reset
REQ-020 On Reset=1 at a Clock edge: state IDLE, Step=0, Step_Index=0, Busy=0, Cycle_Done=0, latched Halt cleared, regardless of Tick.
REQ-021 Reset mid-cycle SHALL abort without asserting Cycle_Done.

Configuration
REQ-022 Macro STEP_SEQUENCER_SINGLE_STEP_EN, when defined, SHALL add inputs Single_Mode (1 bit) and Step_Button (1 bit); with Single_Mode=1, advances occur only on a detected rising edge of Step_Button coinciding with Tick=1.
REQ-023 Without the macro, those ports do not exist and behaviour is exactly REQ-013..REQ-019.

Structure
REQ-024 A shared package SHALL hold the state typedef, the index width constant (4), and the maximum step count (16).
REQ-025 One sub-module, step_edge_detect (registered rising-edge detector, Tick-qualified), SHALL be instantiated only under STEP_SEQUENCER_SINGLE_STEP_EN.

Verification
REQ-026 Reset, Tick=1, Run pulse, Last_Step=9 -> Step walks 0x001..0x200 over 10 Ticks, Cycle_Done on index 9, wraps to 0x001.
REQ-027 Last_Step=3, running -> Step sequence 0x001,0x002,0x004,0x008,0x001; Cycle_Done once per 4 Ticks.
REQ-028 Halt pulse at index 2 with Last_Step=5 -> continues to index 5, Cycle_Done=1, then IDLE, Step=0, Busy=0.
REQ-029 Tick held low 3 Clocks at index 4 -> Step stays 0x010; Run=1 & Halt=1 in IDLE -> stays IDLE.
REQ-030 Reset asserted at index 6 -> next Clock Step=0, Busy=0, no Cycle_Done; Last_Step=12 -> treated as 9.
REQ-031 With macro, Single_Mode=1, Step_Button held high 5 Clocks -> exactly one advance.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// Shared types and sizing constants for the step sequencer.
package step_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int IDX_W     = 4;
  localparam int MAX_STEPS = 16;

endpackage

// File: rtl/step_sequencer_edge_detect.sv
// Tick-qualified rising-edge detector for the manual step button.
// Only compiled when STEP_SEQUENCER_SINGLE_STEP_EN is defined.
`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  // The previous level only moves on a tick, so a press that starts between ticks is caught on the next tick.
  always_comb begin
    din_d = din_q;
    if (tick) din_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din_d;
  end

  assign rise = tick & din & ~din_q;

endmodule
`endif

// File: rtl/step_sequencer.sv
// One-hot timing-step generator for a control unit (T1..Tn per instruction cycle).
// Optional single-step mode: define STEP_SEQUENCER_SINGLE_STEP_EN.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int NrOfSteps = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 Run,
  input  logic                 Halt,
  input  logic [IDX_W-1:0]     Last_Step,
  output logic [NrOfSteps-1:0] Step,
  output logic [IDX_W-1:0]     Step_Index,
  output logic                 Busy,
  output logic                 Cycle_Done
`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
  ,
  input  logic                 Single_Mode,
  input  logic                 Step_Button
`endif
);

  localparam logic [IDX_W-1:0]     LAST_MAX   = IDX_W'(NrOfSteps - 1);
  localparam logic [NrOfSteps-1:0] STEP_FIRST = NrOfSteps'(1);

  state_e                 state_q, state_d;
  logic [NrOfSteps-1:0]   step_q, step_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic                   cycle_done_q, cycle_done_d;
  logic                   halt_pend_q, halt_pend_d;
  logic [IDX_W-1:0]       last_eff;
  logic                   advance;

`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
  logic button_rise;

  step_edge_detect u_edge_detect (
    .clk  (Clock),
    .rst  (Reset),
    .tick (Tick),
    .din  (Step_Button),
    .rise (button_rise)
  );

  assign advance = Single_Mode ? button_rise : Tick;
`else
  assign advance = Tick;
`endif

  assign last_eff = (Last_Step > LAST_MAX) ? LAST_MAX : Last_Step;

  // An index at or past the effective last step ends the cycle, so lowering Last_Step mid-cycle ends it early.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    index_d      = index_q;
    cycle_done_d = 1'b0;
    halt_pend_d  = halt_pend_q;
    case (state_q)
      IDLE: begin
        halt_pend_d = 1'b0;
        if (advance && Run && !Halt) begin
          state_d = RUN;
          step_d  = STEP_FIRST;
          index_d = '0;
        end
      end
      RUN: begin
        if (Halt) halt_pend_d = 1'b1;
        if (advance) begin
          if (index_q >= last_eff) begin
            cycle_done_d = 1'b1;
            if (Halt || halt_pend_q) begin
              state_d     = IDLE;
              step_d      = '0;
              index_d     = '0;
              halt_pend_d = 1'b0;
            end else begin
              step_d  = STEP_FIRST;
              index_d = '0;
            end
          end else begin
            step_d  = step_q << 1;
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      index_q      <= '0;
      cycle_done_q <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      index_q      <= index_d;
      cycle_done_q <= cycle_done_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  assign Step       = step_q;
  assign Step_Index = index_q;
  assign Busy       = (state_q == RUN);
  assign Cycle_Done = cycle_done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer (default build, 10 steps).
module tb_step_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Tick;
  logic       Run;
  logic       Halt;
  logic [3:0] Last_Step;
  logic [9:0] Step;
  logic [3:0] Step_Index;
  logic       Busy;
  logic       Cycle_Done;

  int testsRun = 0;
  int testsFailed = 0;

  step_sequencer #(.NrOfSteps(10)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Tick       (Tick),
    .Run        (Run),
    .Halt       (Halt),
    .Last_Step  (Last_Step),
    .Step       (Step),
    .Step_Index (Step_Index),
    .Busy       (Busy),
    .Cycle_Done (Cycle_Done)
  );

  always #5 Clock = ~Clock;

  // Drive one set of inputs and let one rising edge pass; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic rst, input logic tick, input logic run,
                               input logic halt, input logic [3:0] last);
    Reset     = rst;
    Tick      = tick;
    Run       = run;
    Halt      = halt;
    Last_Step = last;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expStep,
                             input logic [3:0] expIdx, input logic expBusy, input logic expDone);
    testsRun++;
    assert (Step === expStep) else begin
      testsFailed++;
      $error("[TB] FAIL %s Step observed %h expected %h", tag, Step, expStep);
    end
    testsRun++;
    assert (Step_Index === expIdx) else begin
      testsFailed++;
      $error("[TB] FAIL %s Step_Index observed %0d expected %0d", tag, Step_Index, expIdx);
    end
    testsRun++;
    assert (Busy === expBusy) else begin
      testsFailed++;
      $error("[TB] FAIL %s Busy observed %b expected %b", tag, Busy, expBusy);
    end
    testsRun++;
    assert (Cycle_Done === expDone) else begin
      testsFailed++;
      $error("[TB] FAIL %s Cycle_Done observed %b expected %b", tag, Cycle_Done, expDone);
    end
  endtask

  // Watchdog so the run always terminates even if the stimulus sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1; Tick = 1'b0; Run = 1'b0; Halt = 1'b0; Last_Step = 4'd9;

    // Reset state
    applyStimulus(1, 0, 0, 0, 4'd9);
    applyStimulus(1, 1, 1, 0, 4'd9);
    checkOutput("reset", 10'h000, 4'd0, 1'b0, 1'b0);

    // Full 10-step walk with wrap
    applyStimulus(0, 1, 1, 0, 4'd9);
    checkOutput("start", 10'h001, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 4'd9);
      checkOutput("walk10", 10'(1 << i), 4'(i), 1'b1, 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 4'd9);
    checkOutput("wrap10", 10'h001, 4'd0, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 4'd9);
    checkOutput("after_wrap10", 10'h002, 4'd1, 1'b1, 1'b0);

    // Early end at Last_Step=3, two consecutive cycles
    applyStimulus(0, 1, 0, 0, 4'd3);
    checkOutput("short_i2", 10'h004, 4'd2, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'd3);
    checkOutput("short_i3", 10'h008, 4'd3, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'd3);
    checkOutput("short_wrap1", 10'h001, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 4'd3);
      checkOutput("short_walk", 10'(1 << i), 4'(i), 1'b1, 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 4'd3);
    checkOutput("short_wrap2", 10'h001, 4'd0, 1'b1, 1'b1);

    // Tick low holds everything at index 4
    for (int i = 1; i < 5; i++) applyStimulus(0, 1, 0, 0, 4'd9);
    checkOutput("reach_i4", 10'h010, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 4'd9);
      checkOutput("tick_hold", 10'h010, 4'd4, 1'b1, 1'b0);
    end

    // Reset at index 6 aborts without Cycle_Done
    applyStimulus(0, 1, 0, 0, 4'd12);
    applyStimulus(0, 1, 0, 0, 4'd12);
    checkOutput("reach_i6", 10'h040, 4'd6, 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 0, 4'd12);
    checkOutput("reset_mid", 10'h000, 4'd0, 1'b0, 1'b0);

    // Last_Step=12 clamps to 9; Run held high while running is ignored
    applyStimulus(0, 1, 1, 0, 4'd12);
    checkOutput("restart", 10'h001, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) applyStimulus(0, 1, 1, 0, 4'd12);
    checkOutput("clamp_i9", 10'h200, 4'd9, 1'b1, 1'b0);
    applyStimulus(0, 1, 1, 0, 4'd12);
    checkOutput("clamp_wrap", 10'h001, 4'd0, 1'b1, 1'b1);

    // Halt pulse at index 2 (with Tick low) is latched until index 5 completes
    applyStimulus(0, 1, 0, 0, 4'd5);
    applyStimulus(0, 1, 0, 0, 4'd5);
    checkOutput("halt_i2", 10'h004, 4'd2, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1, 4'd5);
    checkOutput("halt_pulse", 10'h004, 4'd2, 1'b1, 1'b0);
    for (int i = 3; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0, 4'd5);
      checkOutput("halt_continue", 10'(1 << i), 4'(i), 1'b1, 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 4'd5);
    checkOutput("halt_stop", 10'h000, 4'd0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 0, 4'd5);
    checkOutput("idle_after_halt", 10'h000, 4'd0, 1'b0, 1'b0);

    // Run and Halt together in IDLE: Halt wins
    applyStimulus(0, 1, 1, 1, 4'd9);
    checkOutput("run_halt_idle", 10'h000, 4'd0, 1'b0, 1'b0);

    // Lowering Last_Step below the current index ends the cycle on the next Tick
    applyStimulus(0, 1, 1, 0, 4'd9);
    checkOutput("restart2", 10'h001, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) applyStimulus(0, 1, 0, 0, 4'd9);
    checkOutput("reach_i5", 10'h020, 4'd5, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'd2);
    checkOutput("early_end", 10'h001, 4'd0, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 4'd2);
    checkOutput("after_early", 10'h002, 4'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
